// File: rtl/axi_read_slv_pkg.sv
// Shared encodings, state type and default widths for the AXI read slave.
// burstErr() decides up front whether a request is answered with SLVERR beats only.
package axi_read_slv_pkg;

  localparam int DEF_ARID_WIDTH   = 4;
  localparam int DEF_ARADDR_WIDTH = 10;
  localparam int DEF_RDATA_WIDTH  = 64;
  localparam int DEF_AR_DEPTH     = 4;

  // Widest beat the 64-bit SRAM word can serve is 8 bytes.
  localparam logic [2:0] MAX_SIZE = 3'd3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  function automatic logic burstErr(input logic [1:0] burst, input logic [7:0] len,
                                    input logic [2:0] size, input logic wrapEn);
    logic err;
    err = (size > MAX_SIZE) || (burst == BURST_RSVD);
    if (burst == BURST_WRAP) begin
      err = err || !wrapEn ||
            !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end
    return err;
  endfunction

endpackage

// File: rtl/axi_read_slv_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rdata_o whenever count_o is non-zero.
// Pushes into a full FIFO and pops from an empty one are ignored.
module axi_read_slv_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign doPop   = pop_i && (count_q != '0);
  assign doPush  = push_i && (count_q != CW'(DEPTH));
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= ptrNext(wrPtr_q);
      if (doPop)  rdPtr_q <= ptrNext(rdPtr_q);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_read_slv.sv
// AXI4 read-only slave in front of a 1-cycle-latency SRAM: AR queue, burst FSM, 2-entry R stage.
// Define AXI_READ_SLV_WRAP_EN to support WRAP bursts; otherwise WRAP is answered with SLVERR.
module axi_read_slv
  import axi_read_slv_pkg::*;
#(
  parameter int ARID_WIDTH   = DEF_ARID_WIDTH,
  parameter int ARADDR_WIDTH = DEF_ARADDR_WIDTH,
  parameter int RDATA_WIDTH  = DEF_RDATA_WIDTH,
  parameter int AR_DEPTH     = DEF_AR_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ARID_WIDTH-1:0]   ARID,
  input  logic [ARADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ARID_WIDTH-1:0]   RID,
  output logic [RDATA_WIDTH-1:0]  RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    mem_rd_en,
  output logic [ARADDR_WIDTH-4:0] mem_rd_addr,
  input  logic [RDATA_WIDTH-1:0]  mem_rd_data
);

`ifdef AXI_READ_SLV_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  localparam int AW   = ARADDR_WIDTH;
  localparam int ARCW = $clog2(AR_DEPTH + 1);
  localparam int OUTD = 2;
  localparam int OCW  = $clog2(OUTD + 1);

  typedef struct packed {
    logic [ARID_WIDTH-1:0] id;
    logic [AW-1:0]         addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_t;

  typedef struct packed {
    logic [ARID_WIDTH-1:0]  id;
    logic [1:0]             resp;
    logic                   last;
    logic [RDATA_WIDTH-1:0] data;
  } rbeat_t;

  typedef struct packed {
    logic [ARID_WIDTH-1:0] id;
    logic                  err;
    logic                  last;
  } meta_t;

  ar_t             arIn, arHead;
  logic [ARCW-1:0] arCount;
  logic            arFull, arEmpty, arPush, arPop, arReadyEn_q;

  state_e                state_q, state_d;
  logic [ARID_WIDTH-1:0] id_q;
  logic [AW-1:0]         addr_q, nextAddr, step, wrapMask;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q, load, issue, lastBeat, canIssue;

  logic       infl_q;
  meta_t      inflMeta_q;
  rbeat_t     outIn, outHead;
  logic [OCW-1:0] outCount;
  logic [2:0]     occ;
  logic           outPop;

  assign arIn    = '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
  assign arFull  = (arCount == ARCW'(AR_DEPTH));
  assign arEmpty = (arCount == '0);
  assign ARREADY = arReadyEn_q & ~arFull;
  assign arPush  = ARVALID & ARREADY;

  axi_read_slv_fifo #(.WIDTH($bits(ar_t)), .DEPTH(AR_DEPTH)) u_ar_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (arPush),
    .wdata_i (arIn),
    .pop_i   (arPop),
    .rdata_o (arHead),
    .count_o (arCount)
  );

  // Keeps ARREADY low while in reset and lets it rise on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arReadyEn_q <= 1'b0;
    else        arReadyEn_q <= 1'b1;
  end

  // A beat may issue only if the R stage still has room once this cycle's pop and the read in flight land.
  assign outPop   = RVALID & RREADY;
  assign occ      = 3'(outCount) + 3'(infl_q) - 3'(outPop);
  assign canIssue = (occ < 3'(OUTD));
  assign lastBeat = (beat_q == len_q);

  always_comb begin
    step     = AW'(1) << size_q;
    wrapMask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    unique case (burst_q)
      BURST_FIXED: nextAddr = addr_q;
      BURST_WRAP:  nextAddr = (addr_q & ~wrapMask) | ((addr_q + step) & wrapMask);
      default:     nextAddr = addr_q + step;
    endcase
  end

  always_comb begin
    state_d = state_q;
    arPop   = 1'b0;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!arEmpty) begin
          arPop   = 1'b1;
          load    = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (canIssue) begin
          issue = 1'b1;
          if (lastBeat) begin
            if (!arEmpty) begin
              arPop = 1'b1;
              load  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      infl_q     <= 1'b0;
      inflMeta_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        id_q    <= arHead.id;
        addr_q  <= arHead.addr;
        len_q   <= arHead.len;
        size_q  <= arHead.size;
        burst_q <= arHead.burst;
        err_q   <= burstErr(arHead.burst, arHead.len, arHead.size, WRAP_EN);
        beat_q  <= '0;
      end else if (issue) begin
        addr_q <= nextAddr;
        beat_q <= beat_q + 8'd1;
      end
      infl_q     <= issue;
      inflMeta_q <= '{id: id_q, err: err_q, last: lastBeat};
    end
  end

  // Error beats take the same one-cycle slot as SRAM reads so ordering and credit stay uniform.
  assign mem_rd_en   = issue & ~err_q;
  assign mem_rd_addr = addr_q[AW-1:3];

  always_comb begin
    outIn.id   = inflMeta_q.id;
    outIn.resp = inflMeta_q.err ? RESP_SLVERR : RESP_OKAY;
    outIn.last = inflMeta_q.last;
    outIn.data = inflMeta_q.err ? '0 : mem_rd_data;
  end

  axi_read_slv_fifo #(.WIDTH($bits(rbeat_t)), .DEPTH(OUTD)) u_out_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (infl_q),
    .wdata_i (outIn),
    .pop_i   (outPop),
    .rdata_o (outHead),
    .count_o (outCount)
  );

  assign RVALID = (outCount != '0);
  assign RID    = RVALID ? outHead.id   : '0;
  assign RRESP  = RVALID ? outHead.resp : '0;
  assign RLAST  = RVALID ? outHead.last : 1'b0;
  assign RDATA  = RVALID ? outHead.data : '0;

endmodule
